// File: rtl/lsu.sv
// RV64I load/store unit driving a 64-bit word RAM; sub-word stores use read-modify-write. Optional LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency from accept: load/SD respond in n+2, SB/SH/SW in n+3, errors in n+1.
// One request in flight: req_ready is high only in IDLE; resp_valid is a single pulse with no backpressure.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_A,
  output logic        mem_WE,
  output logic [63:0] mem_WD,
  input  logic [63:0] mem_RD
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_ERR, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [63:0] addr_q, wdata_q, rdata_q, merge_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        accept, illegal, req_bad;
  logic [2:0]  off, eff_off;
  logic [5:0]  shamt;
  logic [3:0]  size, lane_lo, lane_hi;
  logic [63:0] sh, load_ext, wshift, merged;

  assign accept  = req_valid && req_ready;
  assign illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
  assign req_bad = illegal || misalign;
`else
  assign req_bad = illegal;
`endif

  // Natural-alignment truncation is a no-op for accesses that reach here under the trap build.
  assign off = addr_q[2:0];
  always_comb begin
    eff_off = off;
    case (f3_q[1:0])
      2'd1:    eff_off = {off[2:1], 1'b0};
      2'd2:    eff_off = {off[2], 2'b00};
      2'd3:    eff_off = 3'b000;
      default: eff_off = off;
    endcase
  end

  assign size  = 4'd1 << f3_q[1:0];
  assign shamt = {eff_off, 3'b000};
  assign sh    = mem_RD >> shamt;

  always_comb begin
    load_ext = 64'd0;
    case (f3_q)
      3'b000:  load_ext = {{56{sh[7]}},  sh[7:0]};
      3'b001:  load_ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  load_ext = {{32{sh[31]}}, sh[31:0]};
      3'b011:  load_ext = sh;
      3'b100:  load_ext = {56'd0, sh[7:0]};
      3'b101:  load_ext = {48'd0, sh[15:0]};
      3'b110:  load_ext = {32'd0, sh[31:0]};
      default: load_ext = 64'd0;
    endcase
  end

  // Lanes [lo, hi) take the shifted store data; bytes of wdata_q beyond size land outside that window.
  assign lane_lo = {1'b0, eff_off};
  assign lane_hi = lane_lo + size;
  assign wshift  = wdata_q << shamt;

  always_comb begin
    merged = mem_RD;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) >= lane_lo) && (4'(i) < lane_hi))
        merged[8*i +: 8] = wshift[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                  state_nxt = S_ERR;
          else if (!req_we)             state_nxt = S_LOAD;
          else if (req_funct3 == 3'b011) state_nxt = S_WRITE;
          else                          state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_RESP;
      S_WRITE:  state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_RMW_WR;
      S_RMW_WR: state_nxt = S_RESP;
      S_ERR:    state_nxt = S_IDLE;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP) || (state == S_ERR);
    resp_err   = (state == S_ERR);
    resp_rdata = ((state == S_RESP) && !we_q) ? rdata_q : 64'd0;
    mem_WE     = (state == S_WRITE) || (state == S_RMW_WR);
    mem_WD     = 64'd0;
    if (state == S_WRITE)  mem_WD = wdata_q;
    if (state == S_RMW_WR) mem_WD = merge_q;
    mem_A      = {addr_q[63:3], 3'b000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      merge_q <= 64'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        rdata_q <= 64'd0;
      end
      if (state == S_LOAD)   rdata_q <= load_ext;
      if (state == S_RMW_RD) merge_q <= merged;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed plan items, reset abort, then random traffic against a byte-array model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_A;
  logic        mem_WE;
  logic [63:0] mem_WD;
  logic [63:0] mem_RD;

  int total = 0;
  int bad = 0;

  logic [63:0] ram [32] = '{default: 64'd0};
  logic [7:0]  ref_b [256] = '{default: 8'd0};

  always #5 clk = ~clk;

  assign mem_RD = ram[mem_A[7:3]];
  always @(posedge clk) if (mem_WE) ram[mem_A[7:3]] <= mem_WD;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_b[idx*8 + i];
    return w;
  endfunction

  // Byte-addressed architectural model of one request.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] exp_rd, output logic exp_err);
    int size = 1 << f3[1:0];
    int a = int'(addr[7:0]);
    logic [63:0] ones = '1;
    exp_rd  = 64'd0;
    exp_err = we ? f3[2] : (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % size != 0) exp_err = 1'b1;
`else
    a = a - (a % size);
`endif
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_b[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) exp_rd[8*i +: 8] = ref_b[a + i];
        if (!f3[2] && size < 8 && exp_rd[8*size-1]) exp_rd = exp_rd | (ones << (8*size));
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er);
    logic [63:0] exp_rd;
    logic exp_err, we_seen;
    int c, exp_lat;
    model(we, f3, addr, wd, exp_rd, exp_err);
    exp_lat = exp_err ? 1 : (!we || f3 == 3'b011) ? 2 : 3;
    c = 0;
    while (!req_ready && c < 20) begin @(posedge clk); #1; c++; end
    chk("ready_before_req", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = {$urandom, $urandom};
    c = 1;
    we_seen = mem_WE;
    while (!resp_valid && c < 12) begin
      @(posedge clk); #1; c++;
      we_seen = we_seen | mem_WE;
    end
    rd = resp_rdata; er = resp_err;
    chk("latency", 64'(c), 64'(exp_lat));
    chk("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("mem_we_seen", {63'd0, we_seen}, {63'd0, (we && !exp_err)});
    @(posedge clk); #1;
    chk("ram_word", ram[addr[7:3]], ref_word(int'(addr[7:3])));
    chk("ready_after_resp", {63'd0, req_ready}, 64'd1);
    chk("valid_after_resp", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] rd, w18;
    logic er;

    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_we", {63'd0, mem_WE}, 64'd0);
    chk("rst_mem_wd", mem_WD, 64'd0);
    chk("rst_mem_a", mem_A, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, er);
    do_req(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    chk("ld_0x10", rd, 64'h1122334455667788);
    do_req(1'b1, 3'b000, 64'h13, 64'hAA, rd, er);
    chk("sb_word", ram[2], 64'h11223344AA667788);
    do_req(1'b0, 3'b000, 64'h13, 64'd0, rd, er);
    chk("lb_0x13", rd, 64'hFFFFFFFFFFFFFFAA);
    do_req(1'b0, 3'b100, 64'h13, 64'd0, rd, er);
    chk("lbu_0x13", rd, 64'hAA);

    w18 = ram[3];
    do_req(1'b1, 3'b010, 64'h1C, 64'h80000000, rd, er);
    chk("sw_low_word_kept", {32'd0, ram[3][31:0]}, {32'd0, w18[31:0]});
    do_req(1'b0, 3'b010, 64'h1C, 64'd0, rd, er);
    chk("lw_0x1c", rd, 64'hFFFFFFFF80000000);
    do_req(1'b0, 3'b110, 64'h1C, 64'd0, rd, er);
    chk("lwu_0x1c", rd, 64'h80000000);

    do_req(1'b0, 3'b001, 64'h11, 64'd0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh_misalign_err", {63'd0, er}, 64'd1);
`else
    chk("lh_trunc_err", {63'd0, er}, 64'd0);
    chk("lh_trunc_data", rd, 64'h7788);
`endif
    do_req(1'b0, 3'b111, 64'h10, 64'd0, rd, er);
    chk("ld_f3_111_err", {63'd0, er}, 64'd1);
    do_req(1'b1, 3'b101, 64'h10, 64'hFF, rd, er);
    chk("st_f3_101_err", {63'd0, er}, 64'd1);

    // Abort an SH during its read phase; the RAM word must stay untouched.
    ram[4] = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) ref_b[32 + i] = ram[4][8*i +: 8];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 64'h22; req_wdata = 64'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we", {63'd0, mem_WE}, 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_mem_we_after", {63'd0, mem_WE}, 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_ram", ram[4], 64'h0123456789ABCDEF);
    chk("rst_mid_ready_after", {63'd0, req_ready}, 64'd1);
    chk("rst_mid_no_resp", {63'd0, resp_valid}, 64'd0);

    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 64'($urandom_range(0, 255)),
             {$urandom, $urandom}, rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that acts as the initiator on the data-memory port: it accepts one load or store request at a time from the MEM stage and drives the 64-bit word-organised data RAM (`A`/`WE`/`WD`/`RD`; asynchronous read, synchronous write, no byte enables). It performs RV64I load size selection and sign/zero extension, and builds SB/SH/SW stores as a read-modify-write sequence. The pipeline stalls on `req_ready` low and consumes a single-cycle `resp_valid` pulse.

## Interface
- No parameters. Address width is 64 bits and data width is 64 bits, both fixed.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE. A request is accepted when `req_valid` and `req_ready` are both high.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 64: extended load data. It is 0 for stores and errors.
- `resp_err` output 1: qualifies `resp_valid`. Set for an illegal funct3 or for a misaligned access.
- `mem_A` output 64: memory address, always `{addr_q[63:3], 3'b000}`.
- `mem_WE` output 1: memory write enable.
- `mem_WD` output 64: memory write data.
- `mem_RD` input 64: memory read data (combinational from `mem_A`).

## Operation
- Request registering on accept: `addr_q`, `f3_q`, `we_q` and `wdata_q` are captured; `off = addr_q[2:0]`.
- Illegal funct3 (always detected):
  - Load with funct3 = 111.
  - Store with funct3[2] = 1.
- Misaligned access: `off` is not a multiple of the access size (H: `off[0]`; W: `off[1:0]`; D: `off[2:0]`).
- States and transitions:
  - IDLE → ERR on accept if illegal or misaligned.
  - IDLE → LOAD on accept for a load.
  - IDLE → WRITE on accept for SD.
  - IDLE → RMW_RD on accept for SB/SH/SW.
  - LOAD → RESP: `rdata_q` captures the extracted load data.
  - WRITE → RESP: `mem_WE` = 1, `mem_WD` = `wdata_q`.
  - RMW_RD → RMW_WR: `merge_q` captures `mem_RD` with the store lanes replaced.
  - RMW_WR → RESP: `mem_WE` = 1, `mem_WD` = `merge_q`.
  - ERR: `resp_valid` = 1, `resp_err` = 1 → IDLE.
  - RESP: `resp_valid` = 1 → IDLE.
- Load extraction: `sh = mem_RD >> (off*8)`. Take the low 8/16/32/64 bits, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD) to 64 bits.
- Store merge (little-endian): byte lanes `off` .. `off+size-1` of `mem_RD` are replaced by `wdata_q[size*8-1:0]`. All other lanes are preserved.
- `mem_WE` is high only in WRITE and RMW_WR. `mem_WD` is 0 in all other states.
- No memory write ever occurs on an ERR path.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `mem_WE` 0, `mem_WD` 0, `mem_A` 0, and all internal registers 0.
- Cycle numbering: cycle n is the cycle in which the request is accepted.
- Load: LOAD in n+1 (`mem_A` valid); `resp_valid` in n+2; `req_ready` again in n+3.
- SD: WRITE in n+1 (RAM updated at the end of n+1); `resp_valid` in n+2.
- SB/SH/SW: RMW_RD in n+1, RMW_WR in n+2, `resp_valid` in n+3.
- Error: `resp_valid` with `resp_err` in n+1.
- `resp_valid` has no backpressure. Request inputs are ignored when `req_ready` is low.
- Reset mid-operation: state returns to IDLE and `mem_WE` drops asynchronously. A partial RMW is abandoned; the RAM keeps its old word.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access takes the ERR path.
  - No memory read or write occurs for it.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misalignment is not checked.
  - `off` is truncated to natural alignment: H clears bit 0, W clears bits 1:0, D clears bits 2:0.
  - The access proceeds with the truncated offset.
  - `resp_err` is set only for an illegal funct3.

## Test plan
- SD, addr 0x10, data 0x1122334455667788; then LD from 0x10 → `resp_rdata` 0x1122334455667788, `resp_valid` in n+2.
- After the SD above, SB 0xAA to 0x13 → RAM word becomes 0x11223344AA667788 in 3 cycles. Then LB from 0x13 → 0xFFFFFFFFFFFFFFAA; LBU from 0x13 → 0xAA.
- SW 0x80000000 to 0x1C; then LW from 0x1C → 0xFFFFFFFF80000000; LWU from 0x1C → 0x80000000. The lower word at 0x18 is unchanged.
- With the macro: LH from 0x11 → `resp_err` 1 in n+1 and `mem_WE` never asserted. Without the macro: the same request returns the half at 0x10.
- Load with funct3 111 → `resp_err` 1, with or without the macro.
- `rst_n` pulsed low during RMW_RD of an SH → `mem_WE` stays 0, the RAM word is unchanged, and `req_ready` is 1 after release.
